// File: rtl/cache_2way_ctrl_if.sv
// Signal bundle tying the 2-way cache controller to the CPU memory stage, the cache array
// and the block-wide memory bus. master = controller side, slave = environment side.
interface cache_2way_ctrl_if #(
   parameter int OFFSET_WIDTH = 3,
   parameter int INDEX_WIDTH  = 6,
   parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH,
   parameter int BLK_W        = 32 << OFFSET_WIDTH
);
   // CPU side
   logic                    cpu_req;
   logic                    cpu_we;
   logic [3:0]              cpu_byte_en;
   logic [31:0]             cpu_addr;
   logic [31:0]             cpu_wdata;
   logic [31:0]             cpu_rdata;
   logic                    cpu_ready;
   // Cache array side
   logic                    c_enable;
   logic                    c_cmp;
   logic                    c_write;
   logic                    c_valid_in;
   logic [3:0]              c_byte_w_en;
   logic [TAG_WIDTH-1:0]    c_tag_in;
   logic [INDEX_WIDTH-1:0]  c_index;
   logic [OFFSET_WIDTH-1:0] c_word_sel;
   logic [31:0]             c_data_in;
   logic [BLK_W-1:0]        c_data_block_in;
   logic                    c_hit;
   logic                    c_dirty;
   logic                    c_valid_out;
   logic [TAG_WIDTH-1:0]    c_tag_out;
   logic [31:0]             c_data_out;
   logic [BLK_W-1:0]        c_data_wb;
   // Memory side
   logic                    mem_req;
   logic                    mem_we;
   logic [31:0]             mem_addr;
   logic [BLK_W-1:0]        mem_wdata;
   logic [BLK_W-1:0]        mem_rdata;
   logic                    mem_ack;

   modport master (
      input  cpu_req, cpu_we, cpu_byte_en, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ready,
      output c_enable, c_cmp, c_write, c_valid_in, c_byte_w_en, c_tag_in, c_index,
             c_word_sel, c_data_in, c_data_block_in,
      input  c_hit, c_dirty, c_valid_out, c_tag_out, c_data_out, c_data_wb,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      output cpu_req, cpu_we, cpu_byte_en, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ready,
      input  c_enable, c_cmp, c_write, c_valid_in, c_byte_w_en, c_tag_in, c_index,
             c_word_sel, c_data_in, c_data_block_in,
      output c_hit, c_dirty, c_valid_out, c_tag_out, c_data_out, c_data_wb,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/cache_2way_ctrl.sv
// Miss/refill sequencer for a 2-way set-associative cache array (write-back, write-allocate).
// Optional hit/miss/write-back counters are built when CACHE_CTRL_PERF_CNT_EN is defined.
module cache_2way_ctrl #(
   parameter int OFFSET_WIDTH = 3,
   parameter int INDEX_WIDTH  = 6,
   parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH,
   parameter int BLK_W        = 32 << OFFSET_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   cache_2way_ctrl_if.master bus
`ifdef CACHE_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]       perf_hit_cnt,
   output logic [31:0]       perf_miss_cnt,
   output logic [31:0]       perf_wb_cnt
`endif
);
   localparam int LOW_W = OFFSET_WIDTH + 2;

   typedef enum logic [2:0] {
      S_IDLE, S_COMPARE, S_VICTIM, S_WRITEBACK, S_ALLOCATE, S_REFILL
   } state_e;

   state_e                  state_q, state_d;
   logic [29:0]             addr_q;      // word address, byte offset dropped
   logic                    we_q;
   logic [3:0]              be_q;
   logic [31:0]             wdata_q;
   logic [TAG_WIDTH-1:0]    vtag_q;
   logic [BLK_W-1:0]        blk_q;       // victim block, then refill block

   logic [TAG_WIDTH-1:0]    req_tag;
   logic [INDEX_WIDTH-1:0]  req_index;
   logic [OFFSET_WIDTH-1:0] req_word;
   logic                    unused_ok;

   assign req_tag   = addr_q[29 -: TAG_WIDTH];
   assign req_index = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
   assign req_word  = addr_q[OFFSET_WIDTH-1:0];
   assign unused_ok = ^{bus.cpu_addr[1:0], bus.c_valid_out};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         vtag_q  <= '0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && bus.cpu_req) begin
            addr_q  <= bus.cpu_addr[31:2];
            we_q    <= bus.cpu_we;
            be_q    <= bus.cpu_byte_en;
            wdata_q <= bus.cpu_wdata;
         end
         if (state_q == S_VICTIM) begin
            vtag_q <= bus.c_tag_out;
            blk_q  <= bus.c_data_wb;
         end
         if (state_q == S_ALLOCATE && bus.mem_ack) blk_q <= bus.mem_rdata;
      end
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d             = state_q;
      bus.cpu_rdata       = '0;
      bus.cpu_ready       = 1'b0;
      bus.c_enable        = 1'b0;
      bus.c_cmp           = 1'b0;
      bus.c_write         = 1'b0;
      bus.c_valid_in      = 1'b0;
      bus.c_byte_w_en     = '0;
      bus.c_tag_in        = '0;
      bus.c_index         = '0;
      bus.c_word_sel      = '0;
      bus.c_data_in       = '0;
      bus.c_data_block_in = '0;
      bus.mem_req         = 1'b0;
      bus.mem_we          = 1'b0;
      bus.mem_addr        = '0;
      bus.mem_wdata       = '0;

      if (state_q != S_IDLE) begin
         bus.c_enable   = 1'b1;
         bus.c_index    = req_index;
         bus.c_word_sel = req_word;
      end

      unique case (state_q)
         S_IDLE: if (bus.cpu_req) state_d = S_COMPARE;
         S_COMPARE: begin
            bus.c_cmp       = 1'b1;
            bus.c_tag_in    = req_tag;
            bus.c_write     = we_q & bus.c_hit;
            bus.c_byte_w_en = be_q;
            bus.c_data_in   = wdata_q;
            if (bus.c_hit) begin
               bus.cpu_ready = 1'b1;
               bus.cpu_rdata = bus.c_data_out;
               state_d       = S_IDLE;
            end else begin
               state_d = S_VICTIM;
            end
         end
         S_VICTIM: state_d = bus.c_dirty ? S_WRITEBACK : S_ALLOCATE;
         S_WRITEBACK: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = {vtag_q, req_index, {LOW_W{1'b0}}};
            bus.mem_wdata = blk_q;
            if (bus.mem_ack) state_d = S_ALLOCATE;
         end
         S_ALLOCATE: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = {req_tag, req_index, {LOW_W{1'b0}}};
            if (bus.mem_ack) state_d = S_REFILL;
         end
         S_REFILL: begin
            bus.c_write         = 1'b1;
            bus.c_valid_in      = 1'b1;
            bus.c_byte_w_en     = 4'hF;
            bus.c_tag_in        = req_tag;
            bus.c_data_block_in = blk_q;
            state_d             = S_COMPARE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef CACHE_CTRL_PERF_CNT_EN
   logic        replay_q;
   logic [31:0] hit_q, miss_q, wb_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         replay_q <= 1'b0;
         hit_q    <= '0;
         miss_q   <= '0;
         wb_q     <= '0;
      end else begin
         if (state_q == S_REFILL) replay_q <= 1'b1;
         else if (state_q == S_IDLE) replay_q <= 1'b0;
         // Replay hits after a refill are part of the miss, not extra hits.
         if (state_q == S_COMPARE && bus.c_hit && !replay_q && hit_q != '1) hit_q <= hit_q + 32'd1;
         if (state_q == S_COMPARE && state_d == S_VICTIM && miss_q != '1) miss_q <= miss_q + 32'd1;
         if (state_q == S_VICTIM && state_d == S_WRITEBACK && wb_q != '1) wb_q <= wb_q + 32'd1;
      end
   end

   assign perf_hit_cnt  = hit_q;
   assign perf_miss_cnt = miss_q;
   assign perf_wb_cnt   = wb_q;
`endif
endmodule

// File: tb/tb_cache_2way_ctrl.sv
// Bench for cache_2way_ctrl: behavioural 2-way array, latency-programmable memory, and a
// flat golden memory feeding a scoreboard of expected load data.
`timescale 1ns/1ps
module tb_cache_2way_ctrl;
   localparam int OW   = 3;
   localparam int IW   = 6;
   localparam int TW   = 30 - OW - IW;
   localparam int BW   = 32 << OW;
   localparam int SETS = 1 << IW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic arr_rst_n = 1'b0;
   always #5 clk = ~clk;

   cache_2way_ctrl_if #(.OFFSET_WIDTH(OW), .INDEX_WIDTH(IW)) bus ();
`ifdef CACHE_CTRL_PERF_CNT_EN
   logic [31:0] perf_hit_cnt, perf_miss_cnt, perf_wb_cnt;
`endif

   cache_2way_ctrl #(.OFFSET_WIDTH(OW), .INDEX_WIDTH(IW)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus)
`ifdef CACHE_CTRL_PERF_CNT_EN
      ,
      .perf_hit_cnt (perf_hit_cnt),
      .perf_miss_cnt(perf_miss_cnt),
      .perf_wb_cnt  (perf_wb_cnt)
`endif
   );

   // ---------------- behavioural cache array ----------------
   logic [TW-1:0] tag_a [2][SETS];
   logic          val_a [2][SETS];
   logic          dty_a [2][SETS];
   logic [BW-1:0] dat_a [2][SETS];
   logic          lru_a [SETS];     // way to evict when both are valid
   logic          hit0, hit1, vic_w, sel_w;

   always_comb begin
      hit0 = val_a[0][bus.c_index] && (tag_a[0][bus.c_index] == bus.c_tag_in);
      hit1 = val_a[1][bus.c_index] && (tag_a[1][bus.c_index] == bus.c_tag_in);
      if (!val_a[0][bus.c_index])      vic_w = 1'b0;
      else if (!val_a[1][bus.c_index]) vic_w = 1'b1;
      else                             vic_w = lru_a[bus.c_index];
      sel_w           = bus.c_cmp ? hit1 : vic_w;
      bus.c_hit       = bus.c_enable && bus.c_cmp && (hit0 || hit1);
      bus.c_data_out  = dat_a[sel_w][bus.c_index][bus.c_word_sel*32 +: 32];
      bus.c_tag_out   = tag_a[vic_w][bus.c_index];
      bus.c_data_wb   = dat_a[vic_w][bus.c_index];
      bus.c_dirty     = bus.c_enable && !bus.c_cmp && val_a[vic_w][bus.c_index] && dty_a[vic_w][bus.c_index];
      bus.c_valid_out = val_a[sel_w][bus.c_index];
   end

   always @(posedge clk or negedge arr_rst_n) begin
      if (!arr_rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            val_a[0][s] <= 1'b0; val_a[1][s] <= 1'b0;
            dty_a[0][s] <= 1'b0; dty_a[1][s] <= 1'b0;
            lru_a[s]    <= 1'b0;
         end
      end else if (bus.c_enable) begin
         if (bus.c_cmp && bus.c_hit) begin
            lru_a[bus.c_index] <= ~hit1;
            if (bus.c_write) begin
               for (int b = 0; b < 4; b++)
                  if (bus.c_byte_w_en[b])
                     dat_a[hit1][bus.c_index][bus.c_word_sel*32 + b*8 +: 8] <= bus.c_data_in[b*8 +: 8];
               dty_a[hit1][bus.c_index] <= 1'b1;
            end
         end else if (!bus.c_cmp && bus.c_write) begin
            tag_a[vic_w][bus.c_index] <= bus.c_tag_in;
            dat_a[vic_w][bus.c_index] <= bus.c_data_block_in;
            val_a[vic_w][bus.c_index] <= bus.c_valid_in;
            dty_a[vic_w][bus.c_index] <= 1'b0;
            lru_a[bus.c_index]        <= ~vic_w;
         end
      end
   end

   // ---------------- memory and golden model ----------------
   logic [BW-1:0] mem_blk [logic [31:0]];
   logic [31:0]   gold    [logic [31:0]];

   function automatic logic [BW-1:0] blk_init(input logic [31:0] a);
      logic [BW-1:0] b;
      for (int w = 0; w < (1 << OW); w++) b[w*32 +: 32] = (a + 32'(w*4)) ^ 32'hA5A5_0000;
      if (a == 32'h0000_1040) b[31:0] = 32'hDEAD_BEEF;
      return b;
   endfunction

   function automatic logic [BW-1:0] mem_read(input logic [31:0] a);
      if (mem_blk.exists(a)) return mem_blk[a];
      return blk_init(a);
   endfunction

   function automatic logic [31:0] gold_rd(input logic [31:0] addr);
      logic [31:0]   a;
      logic [BW-1:0] b;
      a = {addr[31:2], 2'b00};
      if (gold.exists(a)) return gold[a];
      b = blk_init({addr[31:OW+2], {(OW+2){1'b0}}});
      return b[addr[OW+1:2]*32 +: 32];
   endfunction

   task automatic gold_wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] d);
      logic [31:0] w;
      w = gold_rd(addr);
      for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
      gold[{addr[31:2], 2'b00}] = w;
   endtask

   function automatic logic [BW-1:0] gold_block(input logic [31:0] a);
      logic [BW-1:0] b;
      for (int w = 0; w < (1 << OW); w++) b[w*32 +: 32] = gold_rd(a + 32'(w*4));
      return b;
   endfunction

   int            mem_lat = 1;
   int            mem_cnt = 0;
   int            rd_cnt = 0, wb_cnt = 0;
   logic [31:0]   rd_addr, wb_addr;
   logic [BW-1:0] wb_data;

   // Memory responder: acks after mem_lat idle cycles, ack cycle included in the transaction.
   always @(negedge clk) begin
      if (!bus.mem_req || bus.mem_ack) begin
         bus.mem_ack = 1'b0;
         mem_cnt     = 0;
      end else if (mem_cnt >= mem_lat) begin
         bus.mem_ack = 1'b1;
         if (bus.mem_we) begin
            mem_blk[bus.mem_addr] = bus.mem_wdata;
            wb_addr = bus.mem_addr; wb_data = bus.mem_wdata; wb_cnt++;
         end else begin
            bus.mem_rdata = mem_read(bus.mem_addr);
            rd_addr = bus.mem_addr; rd_cnt++;
         end
      end else begin
         mem_cnt++;
      end
   end

   // ---------------- scoreboard and access driver ----------------
   typedef struct {
      logic        is_load;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;
   exp_t sb_q[$];

   int          n_vec = 0, n_fail = 0;
   bit          mem_seen, stall_bad;
   logic [31:0] first_addr, last_rdata;
   logic        first_we;
   int          mem_hi;

   task automatic do_access(input string name, input logic [31:0] addr, input logic we,
                            input logic [3:0] be, input logic [31:0] wd, input bit noise,
                            output int lat, output bit ok);
      exp_t e;
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_byte_en = be;
      bus.cpu_addr = addr; bus.cpu_wdata = wd;
      e.is_load = !we; e.addr = addr; e.data = gold_rd(addr);
      sb_q.push_back(e);
      if (we) gold_wr(addr, be, wd);
      @(posedge clk);
      lat = 0; ok = 1'b0; mem_seen = 1'b0; stall_bad = 1'b0; mem_hi = 0;
      while (lat < 300 && !ok) begin
         @(negedge clk);
         lat++;
         if (bus.mem_req) begin
            mem_hi++;
            if (!mem_seen) begin
               mem_seen = 1'b1; first_addr = bus.mem_addr; first_we = bus.mem_we;
            end else if (!bus.mem_we && bus.mem_addr !== first_addr) begin
               stall_bad = 1'b1;
            end
         end
         if (bus.cpu_ready) begin
            ok = 1'b1; last_rdata = bus.cpu_rdata; bus.cpu_req = 1'b0;
         end else if (noise) begin
            bus.cpu_req = ~bus.cpu_req; bus.cpu_addr = $urandom; bus.cpu_we = 1'($urandom);
         end else begin
            bus.cpu_req = 1'b0;
         end
      end
      n_vec++;
      e = sb_q.pop_front();
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: no cpu_ready within %0d cycles (addr %h)", name, lat, addr);
      end else if (e.is_load && last_rdata !== e.data) begin
         n_fail++;
         $display("FAIL %s: cpu_rdata %h, expected %h (addr %h)", name, last_rdata, e.data, e.addr);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0; arr_rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({bus.mem_req, bus.cpu_ready, bus.c_enable, bus.c_write} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctl: {mem_req,cpu_ready,c_enable,c_write}=%b, expected 0000",
                  {bus.mem_req, bus.cpu_ready, bus.c_enable, bus.c_write});
      end
      n_vec++;
      if ({bus.mem_addr, bus.cpu_rdata} !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_data: mem_addr %h cpu_rdata %h, expected 0", bus.mem_addr, bus.cpu_rdata);
      end
`ifdef CACHE_CTRL_PERF_CNT_EN
      n_vec++;
      if ({perf_hit_cnt, perf_miss_cnt, perf_wb_cnt} !== 96'd0) begin
         n_fail++;
         $display("FAIL reset_perf: counters %h/%h/%h, expected 0", perf_hit_cnt, perf_miss_cnt, perf_wb_cnt);
      end
`endif
      rst = 1'b1; arr_rst_n = 1'b1;
   endtask

   task automatic test_clean_miss();
      int lat; bit ok;
      mem_lat = 2;
      do_access("miss_load", 32'h0000_1040, 1'b0, 4'h0, 32'h0, 1'b0, lat, ok);
      n_vec++;
      if (first_we !== 1'b0 || first_addr !== 32'h0000_1040) begin
         n_fail++;
         $display("FAIL miss_memreq: mem_we %b mem_addr %h, expected 0 00001040", first_we, first_addr);
      end
      n_vec++;
      if (last_rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL miss_data: cpu_rdata %h, expected deadbeef", last_rdata);
      end
      n_vec++;
      if (lat !== 4 + mem_lat + 1) begin
         n_fail++;
         $display("FAIL miss_latency: %0d cycles, expected %0d", lat, 4 + mem_lat + 1);
      end
      do_access("hit_load", 32'h0000_1040, 1'b0, 4'h0, 32'h0, 1'b0, lat, ok);
      n_vec++;
      if (lat !== 1 || mem_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL hit_latency: %0d cycles mem_seen %b, expected 1 cycle no mem", lat, mem_seen);
      end
   endtask

   task automatic test_store_hit();
      int lat; bit ok;
      do_access("store_hit", 32'h0000_1040, 1'b1, 4'b0011, 32'h1234_5678, 1'b0, lat, ok);
      n_vec++;
      if (lat !== 1 || mem_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL store_hit_mem: %0d cycles mem_seen %b, expected 1 cycle no mem", lat, mem_seen);
      end
      do_access("load_after_store", 32'h0000_1040, 1'b0, 4'h0, 32'h0, 1'b0, lat, ok);
      n_vec++;
      if (last_rdata !== 32'hDEAD_5678) begin
         n_fail++;
         $display("FAIL merged_word: cpu_rdata %h, expected dead5678", last_rdata);
      end
   endtask

   task automatic test_dirty_evict();
      int lat, wb0, rd0; bit ok;
      logic [BW-1:0] exp_blk;
      mem_lat = 1;
      do_access("dirty_st0", 32'h0000_1044, 1'b1, 4'hF, 32'hAAAA_0001, 1'b0, lat, ok);
      do_access("dirty_st1", 32'h0000_1848, 1'b1, 4'hF, 32'hBBBB_0002, 1'b0, lat, ok);
      wb0 = wb_cnt; rd0 = rd_cnt;
      do_access("evict_load", 32'h0000_2040, 1'b0, 4'h0, 32'h0, 1'b0, lat, ok);
      n_vec++;
      if (wb_cnt - wb0 !== 1 || (wb_addr !== 32'h0000_1040 && wb_addr !== 32'h0000_1840)) begin
         n_fail++;
         $display("FAIL wb_addr: %0d write-backs, addr %h, expected 1 to 00001040/00001840", wb_cnt - wb0, wb_addr);
      end
      exp_blk = gold_block(wb_addr);
      n_vec++;
      if (wb_data !== exp_blk) begin
         n_fail++;
         $display("FAIL wb_data: got %h expected %h", wb_data, exp_blk);
      end
      n_vec++;
      if (rd_cnt - rd0 !== 1 || rd_addr !== 32'h0000_2040) begin
         n_fail++;
         $display("FAIL evict_alloc: %0d reads, addr %h, expected 1 at 00002040", rd_cnt - rd0, rd_addr);
      end
      // Evicted line must come back from memory with its stored words intact.
      do_access("evicted_reload0", 32'h0000_1044, 1'b0, 4'h0, 32'h0, 1'b0, lat, ok);
      do_access("evicted_reload1", 32'h0000_1848, 1'b0, 4'h0, 32'h0, 1'b0, lat, ok);
   endtask

   task automatic test_stall();
      int lat; bit ok;
      mem_lat = 20;
      do_access("stall_load", 32'h0000_3080, 1'b0, 4'h0, 32'h0, 1'b1, lat, ok);
      n_vec++;
      if (mem_hi !== 21 || stall_bad !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_hold: mem_req high %0d cycles addr_moved %b, expected 21 stable", mem_hi, stall_bad);
      end
      n_vec++;
      if (lat !== 25) begin
         n_fail++;
         $display("FAIL stall_latency: %0d cycles, expected 25", lat);
      end
      mem_lat = 1;
   endtask

   task automatic test_async_reset();
      int lat, n; bit ok;
      do_access("rst_prep0", 32'h0000_10C0, 1'b1, 4'hF, 32'hC0C0_0010, 1'b0, lat, ok);
      do_access("rst_prep1", 32'h0000_18C0, 1'b1, 4'hF, 32'hC0C0_0018, 1'b0, lat, ok);
      mem_lat = 50;
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_20C0;
      @(negedge clk);
      bus.cpu_req = 1'b0;
      n = 0;
      while (!(bus.mem_req && bus.mem_we) && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_vec++;
      if (!(bus.mem_req && bus.mem_we)) begin
         n_fail++;
         $display("FAIL rst_wb_reach: mem_req %b mem_we %b, expected write-back", bus.mem_req, bus.mem_we);
      end
      #2 rst = 1'b0;
      #1;
      n_vec++;
      if (bus.mem_req !== 1'b0 || bus.c_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: mem_req %b c_enable %b, expected 0 0", bus.mem_req, bus.c_enable);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      mem_lat = 1;
      do_access("post_reset_load", 32'h0000_10C0, 1'b0, 4'h0, 32'h0, 1'b0, lat, ok);
      n_vec++;
      if (lat !== 1) begin
         n_fail++;
         $display("FAIL post_reset_hit: %0d cycles, expected 1", lat);
      end
   endtask

`ifdef CACHE_CTRL_PERF_CNT_EN
   task automatic test_perf();
      int lat; bit ok;
      do_access("perf_prep0", 32'h0000_1140, 1'b1, 4'hF, 32'h1111_0000, 1'b0, lat, ok);
      do_access("perf_prep1", 32'h0000_1940, 1'b1, 4'hF, 32'h2222_0000, 1'b0, lat, ok);
      @(negedge clk) rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      do_access("perf_miss", 32'h0000_1180, 1'b0, 4'h0, 32'h0, 1'b0, lat, ok);
      for (int i = 0; i < 3; i++)
         do_access("perf_hit", 32'h0000_1180 + 32'(i*4), 1'b0, 4'h0, 32'h0, 1'b0, lat, ok);
      do_access("perf_dirty", 32'h0000_2140, 1'b0, 4'h0, 32'h0, 1'b0, lat, ok);
      n_vec++;
      if (perf_hit_cnt !== 32'd3) begin
         n_fail++;
         $display("FAIL perf_hit: %0d, expected 3", perf_hit_cnt);
      end
      n_vec++;
      if (perf_miss_cnt !== 32'd2) begin
         n_fail++;
         $display("FAIL perf_miss: %0d, expected 2", perf_miss_cnt);
      end
      n_vec++;
      if (perf_wb_cnt !== 32'd1) begin
         n_fail++;
         $display("FAIL perf_wb: %0d, expected 1", perf_wb_cnt);
      end
   endtask
`endif

   initial begin
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_byte_en = 4'h0;
      bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
      test_reset();
      test_clean_miss();
      test_store_hit();
      test_dirty_evict();
      test_stall();
      test_async_reset();
`ifdef CACHE_CTRL_PERF_CNT_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
